// File: rtl/oled_digit_streamer.sv
// Streams one SSD1306 frame column by column: digit glyph bytes, optional
// leading-zero blanking, decimal point, zero padding, then a single sync strobe.
module oled_digit_streamer #(
    parameter int DIGITS_NUM       = 6,
    parameter int DIGIT_X_SIZE_PX  = 21,
    parameter int LCD_X_SIZE_PX    = 128,
    parameter int LCD_Y_SIZE_BYTES = 4,
    localparam int DP_SIZE = $clog2(DIGITS_NUM),
    localparam int X_W     = $clog2(DIGIT_X_SIZE_PX),
    localparam int Y_W     = $clog2(LCD_Y_SIZE_BYTES)
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic [4*DIGITS_NUM-1:0] digits_in,
    input  logic [DP_SIZE-1:0]      dec_point_position_in,
    input  logic                    blank_zeros_in,
    input  logic                    refresh_stb_in,
    output logic                    ready_out,
    output logic [3:0]              glyph_digit_out,
    output logic [X_W-1:0]          glyph_x_out,
    output logic [Y_W-1:0]          glyph_y_out,
    output logic                    glyph_dp_out,
    input  logic [7:0]              glyph_pixels_in,
    output logic [7:0]              oled_data_out,
    output logic                    oled_write_stb_out,
    output logic                    oled_sync_stb_out,
    input  logic                    oled_ready_in
);

    localparam int PAD_COLS = LCD_X_SIZE_PX - DIGITS_NUM * DIGIT_X_SIZE_PX;
    localparam int PAD_W    = (PAD_COLS > 0) ? $clog2(PAD_COLS + 1) : 1;
    localparam int DIG_W    = DP_SIZE;

    localparam logic [X_W-1:0]   X_LAST   = X_W'(DIGIT_X_SIZE_PX - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(LCD_Y_SIZE_BYTES - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS_NUM - 1);
    localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PAD_COLS - 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_SEND_DATA,
        S_WAIT_FOR_READY,
        S_SEND_SYNC,
        S_WAIT_FOR_SYNC
    } state_t;

    state_t state, state_next;

    logic [4*DIGITS_NUM-1:0] digits_q, pend_digits;
    logic [DP_SIZE-1:0]      dp_q, pend_dp;
    logic                    blank_q, pend_blank, pending;

    logic [DIG_W-1:0] digit_cnt;
    logic [X_W-1:0]   x_cnt;
    logic [Y_W-1:0]   y_cnt;
    logic [PAD_W-1:0] pad_cnt;
    logic             in_pad;

    logic             frame_start, advance, last_byte;
    logic [3:0]       cur_digit;
    logic             cur_blank, lead_zero;

    assign last_byte = (y_cnt == Y_LAST) &&
                       (in_pad ? (pad_cnt == PAD_LAST)
                               : ((PAD_COLS == 0) && (digit_cnt == '0) && (x_cnt == X_LAST)));

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // A refresh coinciding with the sync handshake exit restarts immediately.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        advance     = 1'b0;
        case (state)
            S_RESET: state_next = S_IDLE;
            S_IDLE: begin
                if (refresh_stb_in || pending) begin
                    state_next  = S_SEND_DATA;
                    frame_start = 1'b1;
                end
            end
            S_SEND_DATA: begin
                if (!oled_ready_in) begin
                    state_next = S_WAIT_FOR_READY;
                end
            end
            S_WAIT_FOR_READY: begin
                if (oled_ready_in) begin
                    if (last_byte) begin
                        state_next = S_SEND_SYNC;
                    end else begin
                        advance    = 1'b1;
                        state_next = S_SEND_DATA;
                    end
                end
            end
            S_SEND_SYNC: begin
                if (!oled_ready_in) begin
                    state_next = S_WAIT_FOR_SYNC;
                end
            end
            S_WAIT_FOR_SYNC: begin
                if (oled_ready_in) begin
                    if (refresh_stb_in || pending) begin
                        state_next  = S_SEND_DATA;
                        frame_start = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            digits_q    <= '0;
            dp_q        <= '0;
            blank_q     <= 1'b0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blank  <= 1'b0;
            pending     <= 1'b0;
            digit_cnt   <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            pad_cnt     <= '0;
            in_pad      <= 1'b0;
        end else if (frame_start) begin
            // A strobe in this very cycle is newer than anything buffered.
            if (refresh_stb_in) begin
                digits_q <= digits_in;
                dp_q     <= dec_point_position_in;
                blank_q  <= blank_zeros_in;
            end else begin
                digits_q <= pend_digits;
                dp_q     <= pend_dp;
                blank_q  <= pend_blank;
            end
            pending   <= 1'b0;
            digit_cnt <= DIG_LAST;
            x_cnt     <= '0;
            y_cnt     <= '0;
            pad_cnt   <= '0;
            in_pad    <= 1'b0;
        end else begin
            if (refresh_stb_in) begin
                pending     <= 1'b1;
                pend_digits <= digits_in;
                pend_dp     <= dec_point_position_in;
                pend_blank  <= blank_zeros_in;
            end
            if (advance) begin
                if (y_cnt != Y_LAST) begin
                    y_cnt <= y_cnt + Y_W'(1);
                end else begin
                    y_cnt <= '0;
                    if (in_pad) begin
                        pad_cnt <= pad_cnt + PAD_W'(1);
                    end else if (x_cnt != X_LAST) begin
                        x_cnt <= x_cnt + X_W'(1);
                    end else begin
                        x_cnt <= '0;
                        if (digit_cnt != '0) begin
                            digit_cnt <= digit_cnt - DIG_W'(1);
                        end else begin
                            in_pad <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Leading zeros are scanned from the most significant digit downwards.
    always_comb begin
        lead_zero = 1'b1;
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = DIGITS_NUM - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (digits_q[4*i +: 4] == 4'd0);
            if (digit_cnt == DIG_W'(i)) begin
                cur_digit = digits_q[4*i +: 4];
                cur_blank = blank_q && lead_zero && (i > int'(dp_q)) && (i != 0);
            end
        end
    end

    assign glyph_digit_out    = cur_digit;
    assign glyph_x_out        = x_cnt;
    assign glyph_y_out        = y_cnt;
    assign glyph_dp_out       = (dp_q == digit_cnt) && (dp_q != '0);

    assign oled_data_out      = ((state == S_SEND_DATA || state == S_WAIT_FOR_READY) &&
                                 !in_pad && !cur_blank) ? glyph_pixels_in : 8'h00;
    assign oled_write_stb_out = (state == S_SEND_DATA);
    assign oled_sync_stb_out  = (state == S_SEND_SYNC);
    assign ready_out          = (state == S_IDLE) && !pending;

endmodule
